// File: rtl/cpu_opponent_ctrl.sv
// cpu_opponent_ctrl: frame-rate CPU opponent emitting player keycodes (left/right/jump/kick).
// Define CPU_JITTER_EN to stretch IDLE/COOL by 0-7 frames from an 8-bit LFSR.
module cpu_opponent_ctrl #(
  parameter int REACT_FRAMES = 8,
  parameter int KICK_FRAMES  = 6,
  parameter int COOL_FRAMES  = 20,
  parameter int TRACK_OFS    = 20,
  parameter int DEADBAND     = 2,
  parameter int KICK_RANGE   = 40,
  parameter int JUMP_RANGE   = 30,
  parameter int JUMP_TRIG    = 40,
  parameter int GROUND_Y     = 257
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       goal_reset,
  input  logic       enable,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  output logic [7:0] keycode,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {IDLE = 3'd0, CHASE = 3'd1, JUMP = 3'd2, AIR = 3'd3, KICK = 3'd4, COOL = 3'd5} state_t;
  localparam logic [4:0] REACT_LAST = 5'(REACT_FRAMES - 1);
  localparam logic [4:0] KICK_LAST = 5'(KICK_FRAMES - 1);
  localparam logic [4:0] COOL_LAST = 5'(COOL_FRAMES - 1);
  // Tracking is done on PlayerX - BallX so the target itself never needs an extra bit.
  localparam logic signed [10:0] LEFT_TH = 11'(TRACK_OFS + DEADBAND);
  localparam logic signed [10:0] RIGHT_TH = 11'(TRACK_OFS - DEADBAND);
  localparam logic signed [10:0] KICK_R = 11'(KICK_RANGE);
  localparam logic signed [10:0] JUMP_R = 11'(JUMP_RANGE);
  localparam logic signed [10:0] NJUMP_R = 11'(-JUMP_RANGE);
  localparam logic signed [10:0] JTRIG = 11'(JUMP_TRIG);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, idle_last, cool_last;
  logic [7:0] key_q, key_d, trk;
  logic signed [10:0] dx, dy;
  logic kick_ok, jump_ok, on_ground, halt;
  assign dx = $signed({1'b0, PlayerX}) - $signed({1'b0, BallX});
  assign dy = $signed({1'b0, PlayerY}) - $signed({1'b0, BallY});
  assign kick_ok = dx >= 11'sd0 && dx <= KICK_R;
  assign jump_ok = dx >= NJUMP_R && dx <= JUMP_R && dy > JTRIG;
  assign on_ground = PlayerY == 10'(GROUND_Y);
  assign trk = {6'd0, dx < RIGHT_TH, dx > LEFT_TH};
  assign halt = goal_reset | ~enable;
`ifdef CPU_JITTER_EN
  localparam logic [7:0] SEED = 8'hA5;
  logic [7:0] lfsr_q;
  logic [2:0] ext_q;
  logic enter;
  assign enter = (state_d == IDLE || state_d == COOL) && (state_d != state_q || halt);
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      lfsr_q <= SEED;
      ext_q <= SEED[2:0];
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (enter) ext_q <= lfsr_q[2:0];
    end
  assign idle_last = REACT_LAST + {2'b0, ext_q};
  assign cool_last = COOL_LAST + {2'b0, ext_q};
`else
  assign idle_last = REACT_LAST;
  assign cool_last = COOL_LAST;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    key_d = trk;
    case (state_q)
      IDLE: begin
        key_d = 8'h00;
        state_d = cnt_q == idle_last ? CHASE : IDLE;
        cnt_d = cnt_q == idle_last ? 5'd0 : cnt_q + 5'd1;
      end
      CHASE:
        if (kick_ok) begin
          state_d = KICK;
          key_d = 8'h08;
          cnt_d = 5'd0;
        end else if (jump_ok && on_ground) begin
          state_d = JUMP;
          key_d = trk | 8'h04;
        end
      JUMP: state_d = AIR;
      AIR: state_d = on_ground ? CHASE : AIR;
      // The exit edge already shows the cooldown keycode so bit3 is held exactly KICK_FRAMES frames.
      KICK: begin
        key_d = cnt_q == KICK_LAST ? trk : 8'h08;
        state_d = cnt_q == KICK_LAST ? COOL : KICK;
        cnt_d = cnt_q == KICK_LAST ? 5'd0 : cnt_q + 5'd1;
      end
      COOL: begin
        state_d = cnt_q == cool_last ? CHASE : COOL;
        cnt_d = cnt_q == cool_last ? 5'd0 : cnt_q + 5'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d = 5'd0;
        key_d = 8'h00;
      end
    endcase
    if (halt) begin
      state_d = IDLE;
      cnt_d = 5'd0;
      key_d = 8'h00;
    end
  end
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      key_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  assign keycode = key_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_cpu_opponent_ctrl.sv
// tb_cpu_opponent_ctrl: directed checks of reset, tracking, kick/cool, jump/air and abort paths.
module tb_cpu_opponent_ctrl;
  logic frame_clk, Reset, goal_reset, enable;
  logic [9:0] BallX, BallY, PlayerX, PlayerY;
  logic [7:0] keycode;
  logic [2:0] state_dbg;
  int checks = 0;
  int errors = 0;

  cpu_opponent_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .goal_reset(goal_reset), .enable(enable),
    .BallX(BallX), .BallY(BallY), .PlayerX(PlayerX), .PlayerY(PlayerY),
    .keycode(keycode), .state_dbg(state_dbg)
  );

  initial frame_clk = 0;
  always #5 frame_clk = ~frame_clk;

`ifdef CPU_JITTER_EN
  logic [7:0] ref_lfsr;
  always @(posedge frame_clk or posedge Reset)
    if (Reset) ref_lfsr <= 8'hA5;
    else ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  function automatic int jit();
    return int'(ref_lfsr[2:0]);
  endfunction
`else
  function automatic int jit();
    return 0;
  endfunction
`endif

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_pos(input int px, input int py, input int bx, input int by);
    PlayerX = 10'(px);
    PlayerY = 10'(py);
    BallX = 10'(bx);
    BallY = 10'(by);
  endtask

  task automatic expect_out(input string nm, input logic [7:0] k, input logic [2:0] s);
    checks++;
    if (keycode !== k || state_dbg !== s) begin
      errors++;
      $display("FAIL %s: keycode=%h state=%0d, required keycode=%h state=%0d", nm, keycode, state_dbg, k, s);
    end
  endtask

  task automatic wait_idle(input string nm, input int n);
    for (int e = 1; e <= n; e++) begin
      tick();
      expect_out(nm, 8'h00, e == n ? 3'd1 : 3'd0);
    end
  endtask

  task automatic test_reset();
    Reset = 1;
    goal_reset = 0;
    enable = 1;
    set_pos(400, 257, 100, 200);
    #1;
    expect_out("reset_async", 8'h00, 3'd0);
    tick();
    tick();
    expect_out("reset_held", 8'h00, 3'd0);
    Reset = 0;
    wait_idle("reset_idle", 8 + jit());
  endtask

  task automatic test_track();
    tick();
    expect_out("track_left", 8'h01, 3'd1);
    set_pos(100, 257, 300, 200);
    tick();
    expect_out("track_right", 8'h02, 3'd1);
    set_pos(399, 257, 400, 280);
    tick();
    expect_out("ball_right_no_kick", 8'h02, 3'd1);
    set_pos(1000, 257, 1015, 280);
    tick();
    expect_out("target_no_wrap", 8'h02, 3'd1);
    set_pos(0, 257, 1000, 280);
    tick();
    expect_out("far_right", 8'h02, 3'd1);
    set_pos(441, 257, 400, 280);
    tick();
    expect_out("kick_edge_plus1", 8'h01, 3'd1);
  endtask

  task automatic test_kick();
    int c;
    set_pos(440, 257, 400, 280);
    tick();
    expect_out("kick_edge", 8'h08, 3'd4);
    set_pos(319, 257, 300, 280);
    for (int i = 2; i <= 6; i++) begin
      tick();
      expect_out("kick_hold", 8'h08, 3'd4);
    end
    c = 20 + jit();
    for (int i = 1; i <= c; i++) begin
      tick();
      expect_out("cool_deadband", 8'h00, 3'd5);
    end
    tick();
    expect_out("cool_exit", 8'h00, 3'd1);
  endtask

  task automatic test_goal_reset();
    int g;
    tick();
    expect_out("rekick_f1", 8'h08, 3'd4);
    tick();
    tick();
    expect_out("rekick_f3", 8'h08, 3'd4);
    goal_reset = 1;
    g = jit();
    tick();
    expect_out("goal_abort", 8'h00, 3'd0);
    goal_reset = 0;
    set_pos(300, 257, 310, 150);
    wait_idle("goal_idle", 8 + g);
  endtask

  task automatic test_jump();
    int g = 0;
    tick();
    expect_out("jump_start", 8'h06, 3'd2);
    PlayerY = 10'd200;
    tick();
    expect_out("jump_to_air", 8'h02, 3'd3);
    set_pos(329, 200, 310, 150);
    tick();
    expect_out("air_no_kick", 8'h00, 3'd3);
    PlayerY = 10'd257;
    tick();
    expect_out("air_land", 8'h00, 3'd1);
    set_pos(300, 257, 310, 150);
    tick();
    expect_out("jump_again", 8'h06, 3'd2);
    PlayerY = 10'd200;
    tick();
    expect_out("air_again", 8'h02, 3'd3);
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      g = jit();
      tick();
      expect_out("disable_air", 8'h00, 3'd0);
    end
    enable = 1;
    set_pos(320, 257, 300, 150);
    wait_idle("enable_idle", 8 + g);
  endtask

  task automatic test_kick_over_jump();
    tick();
    expect_out("kick_beats_jump", 8'h08, 3'd4);
  endtask

  initial begin
    test_reset();
    test_track();
    test_kick();
    test_goal_reset();
    test_jump();
    test_kick_over_jump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
